// File: rtl/register_pkg.sv
// Shared types and widths for the register writeback block.
package register_pkg;

  localparam int unsigned DATA_W         = 32;
  localparam int unsigned ADDR_L         = 32;
  localparam int unsigned ADDR_W         = $clog2(ADDR_L);
  localparam int unsigned FIFO_D_DEFAULT = 4;

  localparam logic [ADDR_W-1:0] ZERO_ADDR = '0;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wb_entry_t;

  localparam int unsigned ENTRY_W = $bits(wb_entry_t);

endpackage

// File: rtl/register_writeback_if.sv
// Result, issue, query and register-file write signals of the writeback block.
interface register_writeback_if;
  import register_pkg::*;

  logic              p_valid;
  logic [ADDR_W-1:0] p_addr;
  logic [DATA_W-1:0] p_data;
  logic              s_valid;
  logic              s_ready;
  logic [ADDR_W-1:0] s_addr;
  logic [DATA_W-1:0] s_data;
  logic              iss_en;
  logic [ADDR_W-1:0] iss_addr;
  logic [ADDR_W-1:0] q1_addr;
  logic [ADDR_W-1:0] q2_addr;
  logic              q1_busy;
  logic              q2_busy;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              wr_en;

  modport slave (
    input  p_valid, p_addr, p_data, s_valid, s_addr, s_data,
    input  iss_en, iss_addr, q1_addr, q2_addr,
    output s_ready, q1_busy, q2_busy, wr_addr, wr_data, wr_en
  );

  modport master (
    output p_valid, p_addr, p_data, s_valid, s_addr, s_data,
    output iss_en, iss_addr, q1_addr, q2_addr,
    input  s_ready, q1_busy, q2_busy, wr_addr, wr_data, wr_en
  );

endinterface

// File: rtl/register_writeback_fifo.sv
// Circular buffer for buffered long-latency results; DEPTH must be a power of 2.
module register_writeback_fifo #(
  parameter int unsigned ENTRY_W = 8,
  parameter int unsigned DEPTH   = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               push,
  input  logic [ENTRY_W-1:0] push_data,
  input  logic               pop,
  output logic [ENTRY_W-1:0] pop_data,
  output logic               full,
  output logic               empty
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [ENTRY_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic [CNT_W-1:0]   count;
  logic               push_ok;
  logic               pop_ok;

  assign full     = (count == CNT_W'(DEPTH));
  assign empty    = (count == '0);
  assign push_ok  = push && !full;
  assign pop_ok   = pop && !empty;
  assign pop_data = mem[rd_ptr];

  // Pointers wrap naturally because DEPTH is a power of 2.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push_ok, pop_ok})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/register_writeback.sv
// Writeback arbiter plus pending-register scoreboard for the register file write port.
// Optional macro REGISTER_WRITEBACK_BYPASS_EN lets an idle-path secondary result skip the FIFO.
module register_writeback
  import register_pkg::*;
#(
  parameter int unsigned FIFO_D = FIFO_D_DEFAULT
) (
  input logic                 clk,
  input logic                 rst,
  register_writeback_if.slave bus
);

  logic [ADDR_L-1:0] pend;
  logic [ADDR_L-1:0] pend_nxt;
  wb_entry_t         s_entry;
  wb_entry_t         head;
  wb_entry_t         ld_entry;
  logic              ld_valid;
  logic              ld_write;
  logic              clr_en;
  logic              fifo_full;
  logic              fifo_empty;
  logic              push;
  logic              pop;
  logic              bypass;
  logic [ADDR_W-1:0] wr_addr_q;
  logic [DATA_W-1:0] wr_data_q;
  logic              wr_en_q;

  assign s_entry     = '{addr: bus.s_addr, data: bus.s_data};
  assign bus.s_ready = !rst && !fifo_full;

`ifdef REGISTER_WRITEBACK_BYPASS_EN
  assign bypass = bus.s_valid && bus.s_ready && fifo_empty && !bus.p_valid;
`else
  assign bypass = 1'b0;
`endif

  assign push = bus.s_valid && bus.s_ready && !bypass;
  assign pop  = !bus.p_valid && !fifo_empty;

  register_writeback_fifo #(
    .ENTRY_W (ENTRY_W),
    .DEPTH   (FIFO_D)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (s_entry),
    .pop       (pop),
    .pop_data  (head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  // Primary results win; otherwise the FIFO head, otherwise (bypass build) a fresh secondary.
  always_comb begin
    ld_valid = 1'b0;
    ld_entry = head;
    clr_en   = 1'b0;
    if (bus.p_valid) begin
      ld_valid = 1'b1;
      ld_entry = '{addr: bus.p_addr, data: bus.p_data};
    end else if (!fifo_empty) begin
      ld_valid = 1'b1;
      clr_en   = 1'b1;
    end else if (bypass) begin
      ld_valid = 1'b1;
      ld_entry = s_entry;
      clr_en   = 1'b1;
    end
  end

  assign ld_write = ld_valid && (ld_entry.addr != ZERO_ADDR);

  // Clear on the load edge, then set so a same-edge issue keeps the bit.
  always_comb begin
    pend_nxt = pend;
    if (clr_en) pend_nxt[ld_entry.addr] = 1'b0;
    if (bus.iss_en && (bus.iss_addr != ZERO_ADDR)) pend_nxt[bus.iss_addr] = 1'b1;
    pend_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pend <= '0;
    end else begin
      pend <= pend_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
    end else begin
      wr_en_q <= ld_write;
      if (ld_write) begin
        wr_addr_q <= ld_entry.addr;
        wr_data_q <= ld_entry.data;
      end
    end
  end

  assign bus.wr_en   = wr_en_q;
  assign bus.wr_addr = wr_addr_q;
  assign bus.wr_data = wr_data_q;
  assign bus.q1_busy = pend[bus.q1_addr];
  assign bus.q2_busy = pend[bus.q2_addr];

endmodule
